// File: rtl/ram_bus_ctrl_if.sv
// Requester-side handshake bundle for ram_bus_ctrl.
// master: a requester pair (drives req/we/addr/wdata, sees ack/rdata).
// slave:  the controller.
interface ram_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [7:0]        wdata0;
  logic [7:0]        wdata1;
  logic              ack0;
  logic              ack1;
  logic [7:0]        rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata
  );
endinterface

// File: rtl/ram_bus_ctrl.sv
// Two-requester controller for an asynchronous 8-bit RAM.
// Sequences IDLE -> SETUP -> STROBE x (WAIT_STATES+1) -> HOLD -> ACK with
// fully registered strobes, address, bus enable, acks and read data.
// Define RAM_BUS_CTRL_RR_EN for round-robin arbitration; otherwise requester 0
// has fixed priority.
module ram_bus_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  ram_bus_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [7:0]        d7_d0,
  output logic              s_,
  output logic              mr_,
  output logic              mw_
);

  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StAck} state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [3:0]        cnt_q;
  logic              s_q;
  logic              mr_q;
  logic              mw_q;
  logic              drive_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [7:0]        rdata_q;
`ifdef RAM_BUS_CTRL_RR_EN
  logic              last_q;
`endif

  logic              req_any;
  logic              pick1;
  logic              gnt_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  // Arbitration and selection of the winning requester's transaction fields.
  always_comb begin
    req_any = bus.req0 | bus.req1;
`ifdef RAM_BUS_CTRL_RR_EN
    // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
    pick1   = bus.req1 & (~bus.req0 | ~last_q);
`else
    pick1   = bus.req1 & ~bus.req0;
`endif
    sel_we    = pick1 ? bus.we1    : bus.we0;
    sel_addr  = pick1 ? bus.addr1  : bus.addr0;
    sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
    gnt_req   = gnt_q ? bus.req1   : bus.req0;
  end

  // Transaction FSM; every RAM-side and requester-side output is a register here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      s_q     <= 1'b1;
      mr_q    <= 1'b1;
      mw_q    <= 1'b1;
      drive_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
`ifdef RAM_BUS_CTRL_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            gnt_q   <= pick1;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            s_q     <= 1'b0;
            // Write data goes on the bus together with the address.
            drive_q <= sel_we;
`ifdef RAM_BUS_CTRL_RR_EN
            last_q  <= pick1;
`endif
            state_q <= StSetup;
          end
        end
        StSetup: begin
          cnt_q   <= WaitInit;
          mr_q    <= we_q;
          mw_q    <= ~we_q;
          state_q <= StStrobe;
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            mr_q <= 1'b1;
            mw_q <= 1'b1;
            if (!we_q) begin
              rdata_q <= d7_d0;
            end
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          s_q     <= 1'b1;
          drive_q <= 1'b0;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= StAck;
        end
        StAck: begin
          if (!gnt_req) begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr      = addr_q;
  assign s_        = s_q;
  assign mr_       = mr_q;
  assign mw_       = mw_q;
  assign d7_d0     = drive_q ? wdata_q : 8'hzz;
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl: a table of single transactions on the
// WAIT_STATES=1 instance, plus sequences for reset, handshake hold,
// arbitration order and the 0/15 wait-state extremes.
module tb_ram_bus_ctrl;
  localparam int unsigned AW = 16;

  typedef struct {
    bit         sel;
    bit         we;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ram_bus_ctrl_if #(.ADDR_W(AW)) bus_if ();
  ram_bus_ctrl_if #(.ADDR_W(AW)) ws0_if ();
  ram_bus_ctrl_if #(.ADDR_W(AW)) ws15_if ();

  wire  [7:0]    d7_d0;
  wire  [7:0]    d_ws0;
  wire  [7:0]    d_ws15;
  logic [AW-1:0] addr, addr_ws0, addr_ws15;
  logic          s_, mr_, mw_;
  logic          s_ws0, mr_ws0, mw_ws0;
  logic          s_ws15, mr_ws15, mw_ws15;

  ram_bus_ctrl #(.ADDR_W(AW), .WAIT_STATES(1)) u_dut (
    .clock(clock), .reset(reset), .bus(bus_if), .addr(addr), .d7_d0(d7_d0),
    .s_(s_), .mr_(mr_), .mw_(mw_)
  );
  ram_bus_ctrl #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .bus(ws0_if), .addr(addr_ws0), .d7_d0(d_ws0),
    .s_(s_ws0), .mr_(mr_ws0), .mw_(mw_ws0)
  );
  ram_bus_ctrl #(.ADDR_W(AW), .WAIT_STATES(15)) u_ws15 (
    .clock(clock), .reset(reset), .bus(ws15_if), .addr(addr_ws15), .d7_d0(d_ws15),
    .s_(s_ws15), .mr_(mr_ws15), .mw_(mw_ws15)
  );

  // RAM model: 256 bytes indexed by the low address byte.
  logic [7:0] mem [256];
  assign d7_d0  = (!s_ && !mr_) ? mem[addr[7:0]] : 8'hzz;
  always @(posedge clock) if (!s_ && !mw_) mem[addr[7:0]] <= d7_d0;
  assign d_ws0  = (!s_ws0 && !mr_ws0)   ? 8'h3C : 8'hzz;
  assign d_ws15 = (!s_ws15 && !mr_ws15) ? 8'hC3 : 8'hzz;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Bus-safety checker on every cycle of every instance.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if ((!mr_ && !mw_) || (!mr_ && u_dut.drive_q) || ((!mr_ || !mw_) && s_) ||
          (!mr_ws0 && !mw_ws0) || ((!mr_ws0 || !mw_ws0) && s_ws0) ||
          (!mr_ws15 && !mw_ws15) || ((!mr_ws15 || !mw_ws15) && s_ws15)) begin
        errors++;
        $display("FAIL strobe_check t=%0t: s_=%b mr_=%b mw_=%b drive=%b, required no overlap",
                 $time, s_, mr_, mw_, u_dut.drive_q);
      end
    end
  end

  task automatic do_txn(input vec_t v, input string tag);
    int lat, strb, bad_addr, bad_data;
    bit done;
    @(posedge clock); #1;
    if (v.sel) begin
      bus_if.we1 = v.we; bus_if.addr1 = v.a; bus_if.wdata1 = v.wd; bus_if.req1 = 1'b1;
    end else begin
      bus_if.we0 = v.we; bus_if.addr0 = v.a; bus_if.wdata0 = v.wd; bus_if.req0 = 1'b1;
    end
    lat = 0; strb = 0; bad_addr = 0; bad_data = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clock); lat++;
      @(negedge clock);
      if (!mr_ || !mw_) begin
        strb++;
        if (addr !== v.a) bad_addr++;
        if (v.we && d7_d0 !== v.wd) bad_data++;
        if (v.we ? !mr_ : !mw_) bad_data++;
      end
      done = v.sel ? bus_if.ack1 : bus_if.ack0;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd5);
    check($sformatf("%s strobe_cycles", tag), 32'(strb), 32'd2);
    check($sformatf("%s addr", tag), 32'(bad_addr), 32'd0);
    check($sformatf("%s data/strobe", tag), 32'(bad_data), 32'd0);
    check($sformatf("%s other_ack", tag), 32'(v.sel ? bus_if.ack0 : bus_if.ack1), 32'd0);
    if (!v.we) check($sformatf("%s rdata", tag), 32'(bus_if.rdata), 32'(v.exp_rd));
    if (v.sel) bus_if.req1 = 1'b0; else bus_if.req0 = 1'b0;
    @(posedge clock); @(negedge clock);
    check($sformatf("%s ack_drop", tag), 32'(bus_if.ack0 | bus_if.ack1), 32'd0);
  endtask

  vec_t vecs [7];
  vec_t v;
  int   order [$];
  int   exp_order [4];
  int   rem0, rem1, bad, lat0, lat15, str0, str15;
  bit   prev0, prev1, done0, done15, found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{sel: 1'b0, we: 1'b1, a: 16'h1234, wd: 8'hA5, exp_rd: 8'h00};
    vecs[1] = '{sel: 1'b1, we: 1'b0, a: 16'h1234, wd: 8'h00, exp_rd: 8'hA5};
    vecs[2] = '{sel: 1'b1, we: 1'b1, a: 16'h00FF, wd: 8'h3C, exp_rd: 8'h00};
    vecs[3] = '{sel: 1'b0, we: 1'b0, a: 16'h00FF, wd: 8'h00, exp_rd: 8'h3C};
    vecs[4] = '{sel: 1'b0, we: 1'b1, a: 16'h1234, wd: 8'h5A, exp_rd: 8'h00};
    vecs[5] = '{sel: 1'b1, we: 1'b0, a: 16'h1234, wd: 8'h00, exp_rd: 8'h5A};
    vecs[6] = '{sel: 1'b0, we: 1'b0, a: 16'h00FF, wd: 8'h00, exp_rd: 8'h3C};
`ifdef RAM_BUS_CTRL_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif

    bus_if.req0 = 0; bus_if.req1 = 0; bus_if.we0 = 0; bus_if.we1 = 0;
    bus_if.addr0 = '0; bus_if.addr1 = '0; bus_if.wdata0 = '0; bus_if.wdata1 = '0;
    ws0_if.req0 = 0; ws0_if.req1 = 0; ws0_if.we0 = 0; ws0_if.we1 = 0;
    ws0_if.addr0 = 16'h0001; ws0_if.addr1 = '0; ws0_if.wdata0 = '0; ws0_if.wdata1 = '0;
    ws15_if.req0 = 0; ws15_if.req1 = 0; ws15_if.we0 = 0; ws15_if.we1 = 0;
    ws15_if.addr0 = 16'h0001; ws15_if.addr1 = '0; ws15_if.wdata0 = '0; ws15_if.wdata1 = '0;
    reset = 1'b1;

    // Reset values.
    #12;
    check("reset s_", 32'(s_), 32'd1);
    check("reset mr_", 32'(mr_), 32'd1);
    check("reset mw_", 32'(mw_), 32'd1);
    check("reset drive", 32'(u_dut.drive_q), 32'd0);
    check("reset acks", 32'({bus_if.ack1, bus_if.ack0}), 32'd0);
    check("reset addr", 32'(addr), 32'd0);
    check("reset rdata", 32'(bus_if.rdata), 32'd0);
    @(negedge clock); reset = 1'b0;

    // Table of single transactions.
    for (int i = 0; i < 7; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Hold req0 after ack: no new cycle, ack stays.
    @(posedge clock); #1;
    bus_if.we0 = 1'b0; bus_if.addr0 = 16'h1234; bus_if.req0 = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clock);
      if (bus_if.ack0) found = 1'b1;
    end
    check("hs ack_rise", 32'(found), 32'd1);
    check("hs rdata", 32'(bus_if.rdata), 32'h5A);
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (!bus_if.ack0 || !s_ || !mr_) bad++;
    end
    check("hs hold", 32'(bad), 32'd0);
    bus_if.req0 = 1'b0;
    @(negedge clock);
    check("hs ack_fall", 32'(bus_if.ack0), 32'd0);
    @(negedge clock);
    check("hs idle s_", 32'(s_), 32'd1);

    // Simultaneous writes, each requester issues two back to back.
    bus_if.we0 = 1'b1; bus_if.addr0 = 16'h0010; bus_if.wdata0 = 8'h11;
    bus_if.we1 = 1'b1; bus_if.addr1 = 16'h0020; bus_if.wdata1 = 8'h22;
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    rem0 = 1; rem1 = 1; prev0 = 1'b0; prev1 = 1'b0;
    for (int c = 0; c < 100 && order.size() < 4; c++) begin
      @(negedge clock);
      if (bus_if.ack0 && !prev0) order.push_back(0);
      if (bus_if.ack1 && !prev1) order.push_back(1);
      prev0 = bus_if.ack0; prev1 = bus_if.ack1;
      if (bus_if.ack0 && bus_if.req0) bus_if.req0 = 1'b0;
      else if (!bus_if.ack0 && !bus_if.req0 && rem0 > 0) begin bus_if.req0 = 1'b1; rem0--; end
      if (bus_if.ack1 && bus_if.req1) bus_if.req1 = 1'b0;
      else if (!bus_if.ack1 && !bus_if.req1 && rem1 > 0) begin bus_if.req1 = 1'b1; rem1--; end
    end
    check("arb grants", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) check($sformatf("arb grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    repeat (2) @(negedge clock);

    // Wait-state extremes, reads on both extra instances at once.
    @(posedge clock); #1;
    ws0_if.req0 = 1'b1; ws15_if.req0 = 1'b1;
    lat0 = 0; lat15 = 0; str0 = 0; str15 = 0; done0 = 1'b0; done15 = 1'b0;
    for (int c = 1; c <= 40 && !(done0 && done15); c++) begin
      @(posedge clock); @(negedge clock);
      if (!done0) begin
        if (!mr_ws0) str0++;
        if (ws0_if.ack0) begin done0 = 1'b1; lat0 = c; ws0_if.req0 = 1'b0; end
      end
      if (!done15) begin
        if (!mr_ws15) str15++;
        if (ws15_if.ack0) begin done15 = 1'b1; lat15 = c; ws15_if.req0 = 1'b0; end
      end
    end
    check("ws0 latency", 32'(lat0), 32'd4);
    check("ws0 strobe_cycles", 32'(str0), 32'd1);
    check("ws0 rdata", 32'(ws0_if.rdata), 32'h3C);
    check("ws15 latency", 32'(lat15), 32'd19);
    check("ws15 strobe_cycles", 32'(str15), 32'd16);
    check("ws15 rdata", 32'(ws15_if.rdata), 32'hC3);
    ws0_if.req0 = 1'b0; ws15_if.req0 = 1'b0;
    repeat (2) @(negedge clock);
    check("ws acks_low", 32'({ws0_if.ack0, ws15_if.ack0}), 32'd0);

    // Reset in the middle of a write strobe.
    @(posedge clock); #1;
    bus_if.we0 = 1'b1; bus_if.addr0 = 16'h0042; bus_if.wdata0 = 8'h77; bus_if.req0 = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clock);
      if (!mw_) found = 1'b1;
    end
    check("rst reached_strobe", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst s_", 32'(s_), 32'd1);
    check("rst mw_", 32'(mw_), 32'd1);
    check("rst mr_", 32'(mr_), 32'd1);
    check("rst drive", 32'(u_dut.drive_q), 32'd0);
    check("rst acks", 32'({bus_if.ack1, bus_if.ack0}), 32'd0);
    bus_if.req0 = 1'b0;
    @(negedge clock); reset = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (!s_ || !mw_ || !mr_ || bus_if.ack0) bad++;
    end
    check("rst idle", 32'(bad), 32'd0);
    v = '{sel: 1'b0, we: 1'b1, a: 16'h0042, wd: 8'h88, exp_rd: 8'h00};
    do_txn(v, "post_rst_wr");
    v = '{sel: 1'b1, we: 1'b0, a: 16'h0042, wd: 8'h00, exp_rd: 8'h88};
    do_txn(v, "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bus_ctrl.md
# ram_bus_ctrl

Synchronous controller that sequences the asynchronous 8-bit RAM (`s_`, `mr_`, `mw_`, bidirectional data bus) and shares it between two requesters. Each requester issues single-byte read or write transactions over a four-phase req/ack handshake. The block arbitrates between them, generates the RAM strobes with a programmable number of wait states, and latches read data. It sits between the processing units and the RAM module on the memory side of the system.

## Interface
- `ADDR_W`, 16, RAM address width; must match the RAM's address width.
- `WAIT_STATES`, 1, extra clock cycles the strobe is held active (0..15); the strobe is active `WAIT_STATES+1` cycles.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `req0`, `req1` in 1: transaction requests; held high until the matching ack is seen.
- `we0`, `we1` in 1: 1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1` in ADDR_W: transaction address; stable while req is high.
- `wdata0`, `wdata1` in 8: write data; stable while req is high.
- `ack0`, `ack1` out 1: transaction complete; `rdata` is valid while ack is high.
- `rdata` out 8: last read byte, shared by both requesters.
- `addr` out ADDR_W: RAM address.
- `d7_d0` inout 8: RAM data bus; driven only during write cycles, otherwise `'hZZ`.
- `s_`, `mr_`, `mw_` out 1: RAM select, read strobe and write strobe, active-low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, ACK.
- IDLE: `s_`=`mr_`=`mw_`=1 and the bus is released.
  - If any req is high, grant one requester, latch its addr/we/wdata into internal registers and go to SETUP.
- SETUP (1 cycle): drive `addr`, `s_`=0, strobes high.
  - On a write, drive the latched wdata on `d7_d0` from this cycle on.
- STROBE (`WAIT_STATES+1` cycles, counted by a 4-bit down-counter): assert `mr_`=0 for a read or `mw_`=0 for a write.
  - `mr_` and `mw_` are never low together.
  - On a read, capture `d7_d0` into `rdata` on the last STROBE edge.
- HOLD (1 cycle): strobes high, `s_`, `addr` and write data still driven (address and data hold).
- ACK: `s_`=1, bus released, ack of the granted requester = 1. Stay until that req goes low, then ack=0 and return to IDLE.
- Arbitration in IDLE only. A grant is never preempted.
- A req that drops before ACK is a protocol violation. The cycle completes regardless and ACK is left as soon as req is low.
- Reset mid-transaction: immediately `s_`=`mr_`=`mw_`=1, bus Z, acks 0, state IDLE. A partially written byte is undefined.

## Timing
- Reset values: `s_`=1, `mr_`=1, `mw_`=1, `d7_d0`=Z, `ack0`=`ack1`=0, `addr`=0, `rdata`=0.
- All outputs are registered; the data-bus enable is registered.
- Latency, req high to ack high: `WAIT_STATES+4` cycles (IDLE sample, SETUP, STROBE×(W+1), HOLD, then ACK).
  - Default: 5 cycles.
- Minimum turnaround, ack high to next grant: 2 cycles (req low seen, IDLE).
- Bus contention margin: the controller drives `d7_d0` only between SETUP and HOLD of a write, so it never overlaps an active `mr_`.

## Configuration
- `RAM_BUS_CTRL_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last` register records the last granted requester and is reset to 1, so requester 0 wins the first tie.
  - On a tie, the requester not granted last wins.
- Not defined: fixed priority; requester 0 always wins a tie. Requester 1 can starve.
- A single requester is served identically in both modes.

## Test plan
- Reset: assert `reset` during STROBE of a write → `mw_`,`s_` go 1 and `d7_d0`=Z before the next edge, acks 0, and the FSM is in IDLE after release.
- Write then read, WAIT_STATES=1:
  - req0, we0=1, addr0=16'h1234, wdata0=8'hA5 → `mw_` low exactly 2 cycles, ack0 5 cycles after req.
  - Then req1 read of 16'h1234 → `rdata`=8'hA5 with ack1.
- Wait states: WAIT_STATES=0 and WAIT_STATES=15 → `mr_` low 1 and 16 cycles, latency 4 and 19 cycles.
- Simultaneous req0/req1 writes, issued twice back to back:
  - With `RAM_BUS_CTRL_RR_EN`: grant order 0,1,0,1.
  - Without it: grant order 0,0,… and req1 served only when req0 is idle.
- Handshake: hold req0 high 10 cycles after ack0 rises → ack0 stays 1, no new cycle starts. Drop req0 → ack0=0 next cycle.
- Strobe checker over all tests: never `mr_`=`mw_`=0; `d7_d0` never driven while `mr_`=0; `s_`=0 whenever a strobe is low.
